// File: rtl/shift_reg_seq.sv
// Multi-mode sequential shifter: loads a word and a shift count, then performs
// one 1-bit shift per enabled clock. Supports left/right direction with logical,
// arithmetic, rotate or serial-in fill. It reports the last bit shifted out,
// a busy flag, the shifts still remaining and a one-cycle done pulse.
module shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] count,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [1:0] M_LOG = 2'b00;
  localparam logic [1:0] M_ARI = 2'b01;
  localparam logic [1:0] M_ROT = 2'b10;
  localparam logic [1:0] M_SER = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ser_out_q, ser_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             fill;

  // Fill bit entering the vacated end, chosen by the latched direction and mode.
  // Left arithmetic behaves like left logical (zero fill).
  always_comb begin
    fill = 1'b0;
    case (mode_q)
      M_LOG: fill = 1'b0;
      M_ARI: fill = dir_q ? 1'b0 : out_q[WIDTH-1];
      M_ROT: fill = dir_q ? out_q[WIDTH-1] : out_q[0];
      M_SER: fill = ser_in;
      default: fill = 1'b0;
    endcase
  end

  // Next-state logic. Load has priority over shifting. Stalls hold every field.
  // done is cleared on every edge that does not set it.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    rem_d     = rem_q;
    ser_out_d = ser_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dir_d     = dir_q;
    mode_d    = mode_q;
    if (load) begin
      out_d     = in;
      rem_d     = count;
      dir_d     = dir;
      mode_d    = mode;
      ser_out_d = 1'b0;
      busy_d    = (count != '0);
      done_d    = (count == '0);
      state_d   = (count != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (dir_q) begin
        out_d     = {out_q[WIDTH-2:0], fill};
        ser_out_d = out_q[WIDTH-1];
      end else begin
        out_d     = {fill, out_q[WIDTH-1:1]};
        ser_out_d = out_q[0];
      end
      rem_d = rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // State registers. Reset aborts any job immediately and issues no done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_q     <= '0;
      rem_q     <= '0;
      ser_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dir_q     <= 1'b0;
      mode_q    <= M_LOG;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      rem_q     <= rem_d;
      ser_out_q <= ser_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
    end
  end

  assign out       = out_q;
  assign ser_out   = ser_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq (WIDTH=8, CNT_W=4). A vector table covers the
// per-cycle behaviour, and hand-written sequences cover reset, long jobs and
// zero-count restart.
module tb_shift_reg_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] in;
  logic [3:0] count;
  logic       dir;
  logic [1:0] mode;
  logic       ser_in;
  logic       en;
  logic [7:0] out;
  logic       ser_out, busy, done;
  logic [3:0] remaining;

  int nvec = 0;
  int errs = 0;

  shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .load(load), .in(in), .count(count), .dir(dir),
    .mode(mode), .ser_in(ser_in), .en(en), .out(out), .ser_out(ser_out),
    .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       load;
    logic [7:0] in;
    logic [3:0] count;
    logic       dir;
    logic [1:0] mode;
    logic       ser_in;
    logic       en;
    logic [7:0] e_out;
    logic       e_ser;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_rem;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] e_out, input logic e_ser,
                       input logic e_busy, input logic e_done, input logic [3:0] e_rem);
    nvec++;
    if (out !== e_out || ser_out !== e_ser || busy !== e_busy || done !== e_done ||
        remaining !== e_rem) begin
      errs++;
      $display("FAIL %s: got out=%h ser=%b busy=%b done=%b rem=%0d, want out=%h ser=%b busy=%b done=%b rem=%0d",
               name, out, ser_out, busy, done, remaining, e_out, e_ser, e_busy, e_done, e_rem);
    end
  endtask

  task automatic drive(input logic l, input logic [7:0] d, input logic [3:0] c, input logic dr,
                       input logic [1:0] m, input logic s, input logic e);
    load = l; in = d; count = c; dir = dr; mode = m; ser_in = s; en = e;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic l, input logic [7:0] d, input logic [3:0] c, input logic dr,
                     input logic [1:0] m, input logic s, input logic e, input logic [7:0] eo,
                     input logic es, input logic eb, input logic ed, input logic [3:0] er);
    vec_t v;
    v = '{l, d, c, dr, m, s, e, eo, es, eb, ed, er};
    vecs.push_back(v);
  endtask

  initial begin
    // Logical right 0xB4 by 3
    add(1, 8'hB4, 3, 0, 2'b00, 0, 1, 8'hB4, 0, 1, 0, 3);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h5A, 0, 1, 0, 2);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h2D, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h16, 1, 0, 1, 0);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h16, 1, 0, 0, 0);
    // Arithmetic right 0x90 by 2
    add(1, 8'h90, 2, 0, 2'b01, 0, 1, 8'h90, 0, 1, 0, 2);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'hC8, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'hE4, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'hE4, 0, 0, 0, 0);
    // Rotate 0x81 left, then right
    add(1, 8'h81, 1, 1, 2'b10, 0, 1, 8'h81, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h03, 1, 0, 1, 0);
    add(1, 8'h81, 1, 0, 2'b10, 0, 1, 8'h81, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'hC0, 1, 0, 1, 0);
    // Logical right 0x80 by 4 with a 2-cycle stall
    add(1, 8'h80, 4, 0, 2'b00, 0, 1, 8'h80, 0, 1, 0, 4);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h40, 0, 1, 0, 3);
    add(0, 8'h00, 0, 0, 2'b00, 0, 0, 8'h40, 0, 1, 0, 3);
    add(0, 8'h00, 0, 0, 2'b00, 0, 0, 8'h40, 0, 1, 0, 3);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h20, 0, 1, 0, 2);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h10, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h08, 0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h08, 0, 0, 0, 0);
    // Serial fill left, ser_in 1,0,1,1
    add(1, 8'h00, 4, 1, 2'b11, 0, 1, 8'h00, 0, 1, 0, 4);
    add(0, 8'h00, 0, 0, 2'b00, 1, 1, 8'h01, 0, 1, 0, 3);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h02, 0, 1, 0, 2);
    add(0, 8'h00, 0, 0, 2'b00, 1, 1, 8'h05, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 2'b00, 1, 1, 8'h0B, 0, 0, 1, 0);
    // Load on the final-shift edge: load wins, no done for the old job
    add(1, 8'h55, 2, 0, 2'b00, 0, 1, 8'h55, 0, 1, 0, 2);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h2A, 1, 1, 0, 1);
    add(1, 8'hA5, 1, 1, 2'b00, 0, 1, 8'hA5, 0, 1, 0, 1);
    add(0, 8'h00, 0, 0, 2'b00, 0, 1, 8'h4A, 1, 0, 1, 0);

    // Reset state
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 2'b00, 0, 0);
    #2;
    check("reset", 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].in, vecs[i].count, vecs[i].dir, vecs[i].mode,
            vecs[i].ser_in, vecs[i].en);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_ser, vecs[i].e_busy,
            vecs[i].e_done, vecs[i].e_rem);
    end

    // Rotate right 0x81 by 9: wraps to 0x81 after 8, 0xC0 after 9
    drive(1, 8'h81, 9, 0, 2'b10, 0, 1);
    step();
    drive(0, 8'h00, 0, 0, 2'b00, 0, 1);
    for (int i = 0; i < 8; i++) step();
    check("rot8", 8'h81, 1, 1, 0, 1);
    step();
    check("rot9", 8'hC0, 1, 0, 1, 0);

    // Arithmetic right 0x80 by 10 saturates to all ones
    drive(1, 8'h80, 10, 0, 2'b01, 0, 1);
    step();
    drive(0, 8'h00, 0, 0, 2'b00, 0, 1);
    for (int i = 0; i < 10; i++) step();
    check("arith_sat", 8'hFF, 1, 0, 1, 0);

    // Reset mid-job: immediate clear, no done afterwards
    drive(1, 8'h00, 4, 1, 2'b11, 0, 1);
    step();
    drive(0, 8'h00, 0, 0, 2'b00, 1, 1);
    step();
    step();
    check("pre_rst", 8'h03, 0, 1, 0, 2);
    #3 rst = 1'b1;
    #1;
    check("async_rst", 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    check("post_rst", 8'h00, 0, 0, 0, 0);

    // Restart with count 0 while busy
    drive(1, 8'hFF, 5, 0, 2'b00, 0, 1);
    step();
    drive(0, 8'h00, 0, 0, 2'b00, 0, 1);
    step();
    check("job5", 8'h7F, 1, 1, 0, 4);
    drive(1, 8'h3C, 0, 0, 2'b00, 0, 1);
    step();
    check("load0", 8'h3C, 0, 0, 1, 0);
    drive(0, 8'h00, 0, 0, 2'b00, 0, 1);
    step();
    check("load0_after", 8'h3C, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
